// File: rtl/alu32_arbiter.sv
// Round-robin arbiter sharing one combinational ALU32 among N_REQ requesters, with a
// single-entry tagged response buffer. Define ALU32_ARB_LOCK_EN to enable grant locking.
module alu32_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_vld_i,
    output logic [N_REQ-1:0]      req_rdy_o,
    input  logic [N_REQ-1:0]      req_lock_i,
    input  logic [2*N_REQ-1:0]    req_ctl_i,
    input  logic [32*N_REQ-1:0]   req_op1_i,
    input  logic [32*N_REQ-1:0]   req_op2_i,
    output logic [1:0]            alu_ctl_o,
    output logic [31:0]           alu_op1_o,
    output logic [31:0]           alu_op2_o,
    input  logic [31:0]           alu_res_i,
    output logic                  rsp_vld_o,
    input  logic                  rsp_rdy_i,
    output logic [31:0]           rsp_res_o,
    output logic [ID_W-1:0]       rsp_id_o
);

    localparam int unsigned NSlots = 1 << ID_W;

    logic              rsp_vld_q, rsp_vld_d;
    logic [31:0]       rsp_res_q, rsp_res_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              can_accept;
    logic [N_REQ-1:0]  elig;
    logic [NSlots-1:0] elig_ext;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;

`ifdef ALU32_ARB_LOCK_EN
    logic              lock_act_q, lock_act_d;
    logic [ID_W-1:0]   lock_owner_q, lock_owner_d;

    // While locked, only the owner stays eligible.
    always_comb begin
        elig = req_vld_i;
        if (lock_act_q) begin
            elig = req_vld_i & (N_REQ'(1) << lock_owner_q);
        end
    end

    always_comb begin
        lock_act_d   = lock_act_q;
        lock_owner_d = lock_owner_q;
        if (gnt_vld) begin
            lock_act_d   = req_lock_i[gnt_idx];
            lock_owner_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_act_q   <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_act_q   <= lock_act_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock_i;
    assign elig        = req_vld_i;
`endif

    assign elig_ext = NSlots'(elig);

    // Scan starts one past the last winner so the last winner has lowest priority.
    always_comb begin
        can_accept = ~rsp_vld_q | rsp_rdy_i;
        gnt_vld    = 1'b0;
        gnt_idx    = '0;
        cand       = '0;
        if (rst_ni && can_accept) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = ID_W'((32'(ptr_q) + k) % N_REQ);
                if (!gnt_vld && elig_ext[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_rdy_o = '0;
        alu_ctl_o = '0;
        alu_op1_o = '0;
        alu_op2_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_vld && (gnt_idx == ID_W'(i))) begin
                req_rdy_o[i] = 1'b1;
                alu_ctl_o    = req_ctl_i[2*i +: 2];
                alu_op1_o    = req_op1_i[32*i +: 32];
                alu_op2_o    = req_op2_i[32*i +: 32];
            end
        end
    end

    // An accept overwrites the buffer even when the old entry drains on the same edge.
    always_comb begin
        rsp_vld_d = rsp_vld_q;
        rsp_res_d = rsp_res_q;
        rsp_id_d  = rsp_id_q;
        ptr_d     = ptr_q;
        if (gnt_vld) begin
            rsp_vld_d = 1'b1;
            rsp_res_d = alu_res_i;
            rsp_id_d  = gnt_idx;
            ptr_d     = gnt_idx;
        end else if (rsp_rdy_i) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_vld_q <= 1'b0;
            rsp_res_q <= '0;
            rsp_id_q  <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_res_q <= rsp_res_d;
            rsp_id_q  <= rsp_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign rsp_vld_o = rsp_vld_q;
    assign rsp_res_o = rsp_res_q;
    assign rsp_id_o  = rsp_id_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Scoreboard bench for alu32_arbiter: driver predicts grants and pushes expected responses,
// an independent monitor pops and compares on each response handshake.
module tb_alu32_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld, req_rdy, req_lock;
    logic [2*N-1:0]  req_ctl;
    logic [32*N-1:0] req_op1, req_op2;
    logic [1:0]      alu_ctl;
    logic [31:0]     alu_op1, alu_op2, alu_res;
    logic            rsp_vld, rsp_rdy;
    logic [31:0]     rsp_res;
    logic [IDW-1:0]  rsp_id;

    always #5 clk = ~clk;

    alu32_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_vld_i  (req_vld),
        .req_rdy_o  (req_rdy),
        .req_lock_i (req_lock),
        .req_ctl_i  (req_ctl),
        .req_op1_i  (req_op1),
        .req_op2_i  (req_op2),
        .alu_ctl_o  (alu_ctl),
        .alu_op1_o  (alu_op1),
        .alu_op2_o  (alu_op2),
        .alu_res_i  (alu_res),
        .rsp_vld_o  (rsp_vld),
        .rsp_rdy_i  (rsp_rdy),
        .rsp_res_o  (rsp_res),
        .rsp_id_o   (rsp_id)
    );

    // Stand-in ALU32: ctl 00 add, 01 sub, 10 and, 11 or.
    function automatic logic [31:0] alu_fn(input logic [1:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_ctl, alu_op1, alu_op2);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [1:0]  t_ctl [N];
    logic [31:0] t_op1 [N];
    logic [31:0] t_op2 [N];
    int          m_ptr = N - 1;
    bit          m_full = 1'b0;
    bit          m_lock_act = 1'b0;
    int          m_lock_owner = 0;
    bit          prev_rst = 1'b0;
    logic [31:0] q_res [$];
    int          q_id [$];

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            t_ctl[i] = 2'($urandom);
            t_op1[i] = $urandom;
            t_op2[i] = $urandom;
        end
    endtask

    task automatic step(input logic [N-1:0] vld, input logic [N-1:0] lk, input logic rdy,
                        input logic rst);
        int win;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst_n    = rst;
        req_vld  = vld;
        req_lock = lk;
        rsp_rdy  = rdy;
        for (int i = 0; i < N; i++) begin
            req_ctl[2*i +: 2]  = t_ctl[i];
            req_op1[32*i +: 32] = t_op1[i];
            req_op2[32*i +: 32] = t_op2[i];
        end
        #1;
        chk("rsp_vld", 64'(rsp_vld), 64'(m_full));
        if (prev_rst) begin
            chk("rst_rsp_res", 64'(rsp_res), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        end
        win = -1;
        if (rst && (!m_full || rdy)) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (win < 0 && vld[i] && (!m_lock_act || i == m_lock_owner)) win = i;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        if (win >= 0) begin
            chk("alu_ctl", 64'(alu_ctl), 64'(t_ctl[win]));
            chk("alu_op1", 64'(alu_op1), 64'(t_op1[win]));
            chk("alu_op2", 64'(alu_op2), 64'(t_op2[win]));
        end else begin
            chk("alu_idle", 64'({alu_ctl, alu_op1 | alu_op2}), 64'd0);
        end
        if (!rst) begin
            q_res.delete();
            q_id.delete();
            m_full     = 1'b0;
            m_ptr      = N - 1;
            m_lock_act = 1'b0;
        end else if (win >= 0) begin
            q_res.push_back(alu_fn(t_ctl[win], t_op1[win], t_op2[win]));
            q_id.push_back(win);
            m_full = 1'b1;
            m_ptr  = win;
`ifdef ALU32_ARB_LOCK_EN
            m_lock_act   = lk[win];
            m_lock_owner = win;
`endif
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        prev_rst = !rst;
    endtask

    // Monitor: a response leaves on rsp_vld & rsp_rdy; it must match the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
                if (q_res.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_spurious: got id %0d res %0h expected no response",
                             rsp_id, rsp_res);
                end else begin
                    logic [31:0] e_res;
                    int          e_id;
                    e_res = q_res.pop_front();
                    e_id  = q_id.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e_id));
                    chk("rsp_res", 64'(rsp_res), 64'(e_res));
                end
            end
        end
    end

    initial begin
        rand_ops();
        rst_n    = 1'b0;
        req_vld  = '1;
        req_lock = '0;
        rsp_rdy  = 1'b1;
        req_ctl  = '0;
        req_op1  = '0;
        req_op2  = '0;
        @(posedge clk);
        step(4'hF, 4'h0, 1'b1, 1'b0);

        // First grant after reset goes to requester 0
        step(4'hF, 4'h0, 1'b1, 1'b1);
        chk("first_grant", 64'(req_rdy), 64'(4'b0001));

        // Single op from requester 1
        step(4'h0, 4'h0, 1'b1, 1'b0);
        t_ctl[1] = 2'b00;
        t_op1[1] = 32'hFF;
        t_op2[1] = 32'h0F;
        step(4'b0010, 4'h0, 1'b1, 1'b1);
        chk("single_rdy", 64'(req_rdy), 64'(4'b0010));
        chk("single_op1", 64'(alu_op1), 64'h0FF);
        step(4'h0, 4'h0, 1'b1, 1'b1);
        chk("single_id", 64'(rsp_id), 64'd1);
        chk("single_res", 64'(rsp_res), 64'h10E);

        // Fairness: all valid, grants rotate 0,1,2,3,0,1
        step(4'h0, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            step(4'hF, 4'h0, 1'b1, 1'b1);
            chk("fair_grant", 64'(req_rdy), 64'(4'b0001 << (k % 4)));
        end

        // Backpressure for 3 cycles, then drain+accept in one edge
        rand_ops();
        for (int k = 0; k < 3; k++) step(4'hF, 4'h0, 1'b0, 1'b1);
        step(4'hF, 4'h0, 1'b1, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b1);
        chk("bp_still_full", 64'(rsp_vld), 64'd1);

        // Reset mid-operation with ptr at 2
        step(4'h0, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step(4'hF, 4'h0, 1'b1, 1'b1);
        end
        step(4'hF, 4'h0, 1'b0, 1'b0);
        step(4'hF, 4'h0, 1'b1, 1'b1);
        chk("midrst_grant", 64'(req_rdy), 64'(4'b0001));

`ifdef ALU32_ARB_LOCK_EN
        // Lock: req 2 holds the ALU while 0 and 3 wait
        step(4'h0, 4'h0, 1'b1, 1'b0);
        step(4'b0100, 4'b0100, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step(4'b1101, 4'b0100, 1'b1, 1'b1);
            chk("lock_hold", 64'(req_rdy), 64'(4'b0100));
        end
        step(4'b1101, 4'b0000, 1'b1, 1'b1);
        step(4'b1101, 4'b0000, 1'b1, 1'b1);
        chk("lock_release", 64'(req_rdy), 64'(4'b1000));
`endif

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] lk;
            rand_ops();
            lk = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            step(N'($urandom), lk, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) != 0));
        end

        step(4'h0, 4'h0, 1'b1, 1'b1);
        step(4'h0, 4'h0, 1'b1, 1'b1);
        chk("queue_drained", 64'(q_res.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
